// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a two-entry skid buffer.
// Upstream ready comes straight from a flop; flush drops held beats and counts the kills.
module pipe_stage_reg #(
    parameter int          INSTR_W   = 32,
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [INSTR_W-1:0] NopVal = INSTR_W'(NOP_INSTR);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               outValid_q, outValid_d;
    logic               inReady_q, inReady_d;
    logic [INSTR_W-1:0] mainInstr_q, mainInstr_d;
    logic [PC_W-1:0]    mainPc_q, mainPc_d;
    logic [INSTR_W-1:0] skidInstr_q, skidInstr_d;
    logic [PC_W-1:0]    skidPc_q, skidPc_d;
    logic [CNT_W-1:0]   flushCnt_q, flushCnt_d;

    logic acc;
    logic dep;

    assign acc = in_valid & inReady_q;
    assign dep = outValid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        mainInstr_d = mainInstr_q;
        mainPc_d    = mainPc_q;
        skidInstr_d = skidInstr_q;
        skidPc_d    = skidPc_q;
        flushCnt_d  = flushCnt_q;

        if (flush) begin
            // Flush wins over every handshake; main keeps its PC so out_pc only goes invalid.
            state_d = EMPTY;
            if ((state_q != EMPTY || acc) && flushCnt_q != '1) begin
                flushCnt_d = flushCnt_q + CNT_W'(1);
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d     = ONE;
                        mainInstr_d = in_instr;
                        mainPc_d    = in_pc;
                    end
                end
                ONE: begin
                    if (acc && dep) begin
                        mainInstr_d = in_instr;
                        mainPc_d    = in_pc;
                    end else if (acc) begin
                        state_d     = FULL;
                        skidInstr_d = in_instr;
                        skidPc_d    = in_pc;
                    end else if (dep) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (dep) begin
                        state_d     = ONE;
                        mainInstr_d = skidInstr_q;
                        mainPc_d    = skidPc_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        outValid_d = (state_d != EMPTY);
        inReady_d  = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            outValid_q  <= 1'b0;
            inReady_q   <= 1'b1;
            mainInstr_q <= NopVal;
            mainPc_q    <= '0;
            skidInstr_q <= '0;
            skidPc_q    <= '0;
            flushCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            outValid_q  <= outValid_d;
            inReady_q   <= inReady_d;
            mainInstr_q <= mainInstr_d;
            mainPc_q    <= mainPc_d;
            skidInstr_q <= skidInstr_d;
            skidPc_q    <= skidPc_d;
            flushCnt_q  <= flushCnt_d;
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_instr = outValid_q ? mainInstr_q : NopVal;
    assign out_pc    = mainPc_q;
    assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, multi-cycle corner sequences and
// a random run checked against a queue-based model of the stage's contents.
module tb_pipe_stage_reg;

    localparam int          CNT_W  = 8;
    localparam int          CntMax = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [7:0]  flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .INSTR_W(32), .PC_W(32), .NOP_INSTR(32'h00000013), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .flush_cnt(flush_cnt)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } beat_t;

    // Model: the stage is just an ordered list of at most two beats.
    beat_t       mq[$];
    logic [31:0] mLastPc;
    int          mCnt;

    logic [31:0] emitted[$];
    int          emitCyc[$];
    int          cycNo = 0;

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        eValid;
        logic [31:0] eInstr;
        logic [31:0] ePc;
        logic        eReady;
        logic [31:0] eCnt;
    } vec_t;

    vec_t vecs[11];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void modelReset();
        mq.delete();
        mLastPc = '0;
        mCnt    = 0;
    endfunction

    function automatic void modelStep(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                                      input logic ordy, input logic fl);
        bit    acc;
        bit    dep;
        beat_t b;
        acc = iv && (mq.size() < 2);
        dep = (mq.size() > 0) && ordy;
        if (fl) begin
            if ((mq.size() > 0 || acc) && mCnt < CntMax) mCnt++;
            mq.delete();
        end else begin
            if (dep) void'(mq.pop_front());
            if (acc) begin
                b.instr = ins;
                b.pc    = pc;
                mq.push_back(b);
            end
        end
        if (mq.size() > 0) mLastPc = mq[0].pc;
    endfunction

    // Called at a falling edge: drive, clock once, update model, return at next falling edge.
    task automatic applyStimulus(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic ordy, input logic fl);
        logic        pStall;
        logic [31:0] pInstr;
        logic [31:0] pPc;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        if (out_valid && ordy) begin
            emitted.push_back(out_pc);
            emitCyc.push_back(cycNo);
        end
        pStall = out_valid && !ordy && !fl && rst_n;
        pInstr = out_instr;
        pPc    = out_pc;
        @(posedge clk);
        cycNo++;
        if (!rst_n) modelReset();
        else modelStep(iv, ins, pc, ordy, fl);
        @(negedge clk);
        if (pStall) begin
            checkVal("stall_valid", {31'b0, out_valid}, 32'd1);
            checkVal("stall_instr", out_instr, pInstr);
            checkVal("stall_pc", out_pc, pPc);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] eInstr;
        logic [31:0] ePc;
        if (mq.size() > 0) begin
            eInstr = mq[0].instr;
            ePc    = mq[0].pc;
        end else begin
            eInstr = NOP;
            ePc    = mLastPc;
        end
        checkVal({tag, "_valid"}, {31'b0, out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
        checkVal({tag, "_instr"}, out_instr, eInstr);
        checkVal({tag, "_pc"}, out_pc, ePc);
        checkVal({tag, "_ready"}, {31'b0, in_ready}, (mq.size() < 2) ? 32'd1 : 32'd0);
        checkVal({tag, "_cnt"}, {24'b0, flush_cnt}, mCnt);
    endtask

    initial begin
        int          idx;
        int          cntBefore;
        logic        take;
        logic        iv;
        logic        ordy;
        logic        fl;

        vecs[0]  = '{1'b1, 32'h00A00093, 32'h100, 1'b1, 1'b0, 1'b1, 32'h00A00093, 32'h100, 1'b1, 32'd0};
        vecs[1]  = '{1'b0, 32'h0,        32'h0,   1'b1, 1'b0, 1'b0, NOP,          32'h100, 1'b1, 32'd0};
        vecs[2]  = '{1'b1, 32'h11,       32'h104, 1'b0, 1'b0, 1'b1, 32'h11,       32'h104, 1'b1, 32'd0};
        vecs[3]  = '{1'b1, 32'h22,       32'h108, 1'b0, 1'b0, 1'b1, 32'h11,       32'h104, 1'b0, 32'd0};
        vecs[4]  = '{1'b1, 32'h33,       32'h10C, 1'b0, 1'b0, 1'b1, 32'h11,       32'h104, 1'b0, 32'd0};
        vecs[5]  = '{1'b0, 32'h0,        32'h0,   1'b1, 1'b0, 1'b1, 32'h22,       32'h108, 1'b1, 32'd0};
        vecs[6]  = '{1'b1, 32'h44,       32'h110, 1'b1, 1'b0, 1'b1, 32'h44,       32'h110, 1'b1, 32'd0};
        vecs[7]  = '{1'b0, 32'h0,        32'h0,   1'b0, 1'b1, 1'b0, NOP,          32'h110, 1'b1, 32'd1};
        vecs[8]  = '{1'b0, 32'h0,        32'h0,   1'b0, 1'b1, 1'b0, NOP,          32'h110, 1'b1, 32'd1};
        vecs[9]  = '{1'b1, 32'h55,       32'h114, 1'b0, 1'b1, 1'b0, NOP,          32'h110, 1'b1, 32'd2};
        vecs[10] = '{1'b1, 32'h66,       32'h118, 1'b1, 1'b0, 1'b1, 32'h66,       32'h118, 1'b1, 32'd2};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rst_valid", {31'b0, out_valid}, 32'd0);
        checkVal("rst_instr", out_instr, NOP);
        checkVal("rst_pc", out_pc, 32'd0);
        checkVal("rst_ready", {31'b0, in_ready}, 32'd1);
        checkVal("rst_cnt", {24'b0, flush_cnt}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].ins, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
            checkVal($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].eValid});
            checkVal($sformatf("vec%0d_instr", i), out_instr, vecs[i].eInstr);
            checkVal($sformatf("vec%0d_pc", i), out_pc, vecs[i].ePc);
            checkVal($sformatf("vec%0d_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].eReady});
            checkVal($sformatf("vec%0d_cnt", i), {24'b0, flush_cnt}, vecs[i].eCnt);
        end

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        checkOutput("clear");

        // Stream 8 beats: stall downstream until the skid fills, then release.
        emitted.delete(); emitCyc.delete(); idx = 0;
        for (int c = 0; c < 10 && in_ready; c++) begin
            take = in_ready;
            applyStimulus(1'b1, 32'hA000 + idx, idx * 4, 1'b0, 1'b0);
            if (take) idx++;
            checkOutput("stream");
        end
        checkVal("stream_full_ready", {31'b0, in_ready}, 32'd0);
        checkVal("stream_accepted", idx, 32'd2);
        for (int c = 0; c < 40 && emitted.size() < 8; c++) begin
            take = in_ready;
            iv   = (idx < 8);
            applyStimulus(iv, 32'hA000 + idx, idx * 4, 1'b1, 1'b0);
            if (take && iv) idx++;
            checkOutput("stream");
        end
        checkVal("stream_count", emitted.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < emitted.size()) checkVal($sformatf("stream_order%0d", i), emitted[i], i * 4);
        end
        if (emitCyc.size() == 8) checkVal("stream_gapless", emitCyc[7] - emitCyc[0], 32'd7);

        // Flush while FULL with an incoming beat: all three beats must vanish.
        applyStimulus(1'b1, 32'h4040, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h4044, 32'h44, 1'b0, 1'b0);
        checkVal("full_ready", {31'b0, in_ready}, 32'd0);
        cntBefore = mCnt;
        applyStimulus(1'b1, 32'h4048, 32'h48, 1'b0, 1'b1);
        checkVal("flush_valid", {31'b0, out_valid}, 32'd0);
        checkVal("flush_instr", out_instr, NOP);
        checkVal("flush_ready", {31'b0, in_ready}, 32'd1);
        checkVal("flush_cnt", {24'b0, flush_cnt}, cntBefore + 1);
        emitted.delete();
        repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkVal("flush_no_ghost", emitted.size(), 32'd0);
        checkOutput("post_flush");

        cntBefore = mCnt;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        checkVal("flush_empty_cnt", {24'b0, flush_cnt}, cntBefore);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 32'h7000 + i, i * 4, 1'b0, 1'b1);
            checkOutput("sat");
        end
        checkVal("sat_cnt", {24'b0, flush_cnt}, 32'd255);

        // Asynchronous reset between edges while FULL.
        applyStimulus(1'b1, 32'h5050, 32'h50, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h5054, 32'h54, 1'b0, 1'b0);
        checkVal("pre_areset_ready", {31'b0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checkVal("areset_valid", {31'b0, out_valid}, 32'd0);
        checkVal("areset_ready", {31'b0, in_ready}, 32'd1);
        checkVal("areset_cnt", {24'b0, flush_cnt}, 32'd0);
        checkVal("areset_instr", out_instr, NOP);
        @(negedge clk);
        modelReset();
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h6060, 32'h60, 1'b1, 1'b0);
        checkVal("post_reset_valid", {31'b0, out_valid}, 32'd1);
        checkVal("post_reset_pc", out_pc, 32'h60);
        checkOutput("post_reset");

        for (int i = 0; i < 10000; i++) begin
            iv   = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            applyStimulus(iv, $urandom, $urandom, ordy, fl);
            checkOutput("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
